// File: rtl/note_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : MIDI package / note_arbiter_if
// Description : Note-change event type and the bundled bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package MIDI;
  typedef struct packed {
    logic       note_on;
    logic [6:0] key;
    logic [6:0] velocity;
  } note_change_t;
endpackage

interface note_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  MIDI::note_change_t   live_note;
  logic                 live_note_ready;
  MIDI::note_change_t   replay_note;
  logic                 replay_note_ready;
  logic                 flush;
  MIDI::note_change_t   note;
  logic                 note_ready;
  logic                 live_overflow;
  logic                 replay_overflow;
  logic [c_CNT_W-1:0]   live_count;
  logic [c_CNT_W-1:0]   replay_count;

  modport master (
    output live_note, live_note_ready, replay_note, replay_note_ready, flush,
    input  note, note_ready, live_overflow, replay_overflow, live_count, replay_count
  );

  modport slave (
    input  live_note, live_note_ready, replay_note, replay_note_ready, flush,
    output note, note_ready, live_overflow, replay_overflow, live_count, replay_count
  );
endinterface

`default_nettype wire

// File: rtl/note_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : note_arbiter
// Description : Two-source note FIFOs with round-robin issue and minimum
//               spacing between issued notes.
// Revision    : 1.0 - initial release
// ============================================================================

module note_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 3
) (
  input  wire logic      clock_50_000_000,
  input  wire logic      reset_l,
  note_arbiter_if.slave  bus
);
  localparam int   c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int   c_CNT_W  = c_PTR_W + 1;
  localparam int   c_GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic c_LIVE   = 1'b0;
  localparam logic c_REPLAY = 1'b1;

  typedef enum logic [0:0] {
    ST_ISSUE = 1'b0,
    ST_GAP   = 1'b1
  } state_t;

  // Index 0 is the live source, index 1 is the replay source.
  logic [1:0]          w_strobe;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [1:0]          w_nonempty;
  logic [1:0]          w_overflow;
  MIDI::note_change_t  w_din   [2];
  MIDI::note_change_t  w_head  [2];
  logic [c_CNT_W-1:0]  w_count [2];

  state_t              r_state;
  logic [c_GAP_W-1:0]  r_gap;
  logic                r_last_grant;
  MIDI::note_change_t  r_note;
  logic                r_note_ready;

  logic                w_grant;
  logic                w_issue;

  assign w_strobe = {bus.replay_note_ready, bus.live_note_ready};
  assign w_din[0] = bus.live_note;
  assign w_din[1] = bus.replay_note;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_fifo
      MIDI::note_change_t  r_mem [FIFO_DEPTH];
      logic [c_PTR_W-1:0]  r_rd_ptr;
      logic [c_PTR_W-1:0]  r_wr_ptr;
      logic [c_CNT_W-1:0]  r_count;
      logic                r_overflow;

      // A full FIFO still accepts a push when it is popped in the same cycle.
      assign w_push[g]     = w_strobe[g] && !bus.flush &&
                             ((r_count < c_CNT_W'(FIFO_DEPTH)) || w_pop[g]);
      assign w_nonempty[g] = (r_count != '0);
      assign w_head[g]     = r_mem[r_rd_ptr];
      assign w_count[g]    = r_count;
      assign w_overflow[g] = r_overflow;

      always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
          r_rd_ptr   <= '0;
          r_wr_ptr   <= '0;
          r_count    <= '0;
          r_overflow <= 1'b0;
        end else if (bus.flush) begin
          r_rd_ptr   <= '0;
          r_wr_ptr   <= '0;
          r_count    <= '0;
        end else begin
          if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop[g])  r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count <= r_count + c_CNT_W'(w_push[g]) - c_CNT_W'(w_pop[g]);
          if (w_strobe[g] && !w_push[g]) r_overflow <= 1'b1;
        end
      end

      always_ff @(posedge clock_50_000_000) begin
        if (w_push[g]) r_mem[r_wr_ptr] <= w_din[g];
      end
    end
  endgenerate

  // On a tie, the source that did not win the previous pop is served.
  assign w_grant  = (w_nonempty[1] && (!w_nonempty[0] || (r_last_grant == c_LIVE)))
                    ? c_REPLAY : c_LIVE;
  assign w_issue  = (r_state == ST_ISSUE) && (|w_nonempty) && !bus.flush;
  assign w_pop[0] = w_issue && (w_grant == c_LIVE);
  assign w_pop[1] = w_issue && (w_grant == c_REPLAY);

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= ST_ISSUE;
      r_gap        <= '0;
      r_last_grant <= c_REPLAY;
      r_note       <= '0;
      r_note_ready <= 1'b0;
    end else begin
      r_note_ready <= 1'b0;
      case (r_state)
        ST_ISSUE: begin
          if (w_issue) begin
            r_note       <= w_head[w_grant];
            r_note_ready <= 1'b1;
            r_last_grant <= w_grant;
            if (GAP_CYCLES > 0) begin
              r_gap   <= c_GAP_W'(GAP_CYCLES);
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          r_gap <= r_gap - 1'b1;
          if (r_gap <= c_GAP_W'(1)) r_state <= ST_ISSUE;
        end
        default: r_state <= ST_ISSUE;
      endcase
    end
  end

  assign bus.note            = r_note;
  assign bus.note_ready      = r_note_ready;
  assign bus.live_overflow   = w_overflow[0];
  assign bus.replay_overflow = w_overflow[1];
  assign bus.live_count      = w_count[0];
  assign bus.replay_count    = w_count[1];

endmodule

`default_nettype wire

// File: tb/tb_note_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_arbiter
// Description : Scoreboard bench for note_arbiter (GAP_CYCLES=3 and 0).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_note_arbiter;
  logic clk;
  logic reset_l;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    MIDI::note_change_t n;
    int                 cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q0[$];

  note_arbiter_if #(.FIFO_DEPTH(4)) a3 ();
  note_arbiter_if #(.FIFO_DEPTH(4)) a0 ();

  note_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(3)) dut3 (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .bus              (a3.slave)
  );

  note_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .bus              (a0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic MIDI::note_change_t mk(input bit on, input int k, input int v);
    MIDI::note_change_t r;
    r.note_on  = on;
    r.key      = 7'(k);
    r.velocity = 7'(v);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push3(input MIDI::note_change_t n, input int c);
    exp_t e;
    e.n = n; e.cyc = c;
    q3.push_back(e);
  endtask

  task automatic push0(input MIDI::note_change_t n, input int c);
    exp_t e;
    e.n = n; e.cyc = c;
    q0.push_back(e);
  endtask

  // Monitors: pop one expectation per issued note.
  always @(negedge clk) begin : mon3
    exp_t e;
    if (reset_l && a3.note_ready) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 spurious note_ready: got note %0h, expected none (cycle %0d)",
                 a3.note, cyc);
      end else begin
        e = q3.pop_front();
        chk("dut3 note", int'(a3.note), int'(e.n));
        chk("dut3 issue cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (reset_l && a0.note_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 spurious note_ready: got note %0h, expected none (cycle %0d)",
                 a0.note, cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0 note", int'(a0.note), int'(e.n));
        chk("dut0 issue cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic s3(input bit lv, input MIDI::note_change_t ln,
                    input bit rv, input MIDI::note_change_t rn);
    a3.live_note = ln; a3.live_note_ready = lv;
    a3.replay_note = rn; a3.replay_note_ready = rv;
    @(negedge clk);
    a3.live_note_ready = 1'b0; a3.replay_note_ready = 1'b0;
  endtask

  task automatic s0(input bit lv, input MIDI::note_change_t ln,
                    input bit rv, input MIDI::note_change_t rn);
    a0.live_note = ln; a0.live_note_ready = lv;
    a0.replay_note = rn; a0.replay_note_ready = rv;
    @(negedge clk);
    a0.live_note_ready = 1'b0; a0.replay_note_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    q3.delete(); q0.delete();
    idle(2);
    reset_l = 1'b1;
    idle(1);
  endtask

  task automatic chk_empty(input string name);
    chk({name, " dut3 notes outstanding"}, q3.size(), 0);
    chk({name, " dut0 notes outstanding"}, q0.size(), 0);
  endtask

  initial begin : stim
    int n;
    errors = 0; checks = 0;
    reset_l = 1'b0;
    a3.live_note = '0; a3.live_note_ready = 1'b0; a3.replay_note = '0;
    a3.replay_note_ready = 1'b0; a3.flush = 1'b0;
    a0.live_note = '0; a0.live_note_ready = 1'b0; a0.replay_note = '0;
    a0.replay_note_ready = 1'b0; a0.flush = 1'b0;
    idle(2);
    reset_l = 1'b1;
    idle(1);

    chk("reset note", int'(a3.note), 0);
    chk("reset note_ready", a3.note_ready, 0);
    chk("reset live_count", a3.live_count, 0);
    chk("reset replay_count", a3.replay_count, 0);
    chk("reset live_overflow", a3.live_overflow, 0);
    chk("reset replay_overflow", a3.replay_overflow, 0);

    // Single live note: issued two cycles after its strobe.
    idle(2);
    n = cyc;
    push3(mk(1, 60, 100), n + 2);
    s3(1, mk(1, 60, 100), 0, '0);
    chk("single live_count after push", a3.live_count, 1);
    idle(1);
    chk("single live_count after pop", a3.live_count, 0);
    idle(6);
    chk_empty("single");

    // Tie from reset goes to live; after a live-only pop the tie goes to replay.
    do_reset();
    n = cyc;
    push3(mk(1, 60, 100), n + 2);
    push3(mk(1, 64, 90),  n + 6);
    s3(1, mk(1, 60, 100), 1, mk(1, 64, 90));
    idle(10);
    n = cyc;
    push3(mk(0, 61, 0), n + 2);
    s3(1, mk(0, 61, 0), 0, '0);
    idle(6);
    n = cyc;
    push3(mk(1, 65, 70), n + 2);
    push3(mk(1, 62, 80), n + 6);
    s3(1, mk(1, 62, 80), 1, mk(1, 65, 70));
    idle(10);
    chk_empty("tie");

    // Seven back-to-back live strobes: six fit, the seventh is dropped.
    do_reset();
    n = cyc;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) chk("flood live_overflow before 7th", a3.live_overflow, 0);
      if (i < 6) push3(mk(1, 40 + i, 10 + i), n + 2 + 4 * i);
      s3(1, mk(1, 40 + i, 10 + i), 0, '0);
    end
    chk("flood live_overflow", a3.live_overflow, 1);
    chk("flood live_count", a3.live_count, 4);
    chk("flood replay_overflow", a3.replay_overflow, 0);
    idle(20);
    chk_empty("flood");

    // Asynchronous reset while in GAP with two entries still queued.
    n = cyc;
    push3(mk(1, 30, 31), n + 2);
    s3(1, mk(1, 30, 31), 0, '0);
    s3(1, mk(1, 32, 33), 0, '0);
    s3(1, mk(1, 34, 35), 0, '0);
    chk("async pre-reset live_count", a3.live_count, 2);
    #2;
    reset_l = 1'b0;
    q3.delete(); q0.delete();
    #1;
    chk("async note", int'(a3.note), 0);
    chk("async note_ready", a3.note_ready, 0);
    chk("async live_count", a3.live_count, 0);
    chk("async replay_count", a3.replay_count, 0);
    chk("async live_overflow", a3.live_overflow, 0);
    idle(2);
    reset_l = 1'b1;
    idle(10);
    chk("async live_count after release", a3.live_count, 0);
    n = cyc;
    push3(mk(0, 70, 5), n + 2);
    s3(1, mk(0, 70, 5), 0, '0);
    idle(6);
    chk_empty("async");

    // Flush on the cycle a replay pop would occur.
    do_reset();
    n = cyc;
    push3(mk(1, 50, 20), n + 2);
    for (int i = 0; i < 4; i++) s3(0, '0, 1, mk(1, 50 + i, 20));
    chk("flush replay_count before", a3.replay_count, 3);
    idle(1);
    a3.flush = 1'b1;
    s3(1, mk(1, 99, 99), 0, '0);
    a3.flush = 1'b0;
    chk("flush replay_count", a3.replay_count, 0);
    chk("flush live_count", a3.live_count, 0);
    chk("flush replay_overflow", a3.replay_overflow, 0);
    chk("flush live_overflow", a3.live_overflow, 0);
    idle(8);
    n = cyc;
    push3(mk(0, 51, 0), n + 2);
    s3(0, '0, 1, mk(0, 51, 0));
    idle(6);
    chk_empty("flush");

    // GAP_CYCLES=0: two pairs issue on four consecutive cycles, alternating.
    n = cyc;
    push0(mk(1, 10, 1), n + 2);
    push0(mk(1, 20, 2), n + 3);
    push0(mk(1, 11, 3), n + 4);
    push0(mk(1, 21, 4), n + 5);
    s0(1, mk(1, 10, 1), 1, mk(1, 20, 2));
    s0(1, mk(1, 11, 3), 1, mk(1, 21, 4));
    idle(8);
    chk("gap0 live_count", a0.live_count, 0);
    chk_empty("gap0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
